// File: rtl/fetch_queue_if.sv
// Fetch queue handshake bundle: producer side (in_*) and consumer side (out_*).
// The slave modport is the queue's view; the master modport is the environment
// that feeds the queue and drains it.
interface fetch_queue_if #(
  parameter int DATA_WD = 64
);
  logic               in_valid;
  logic [DATA_WD-1:0] in_bus;
  logic               in_allowin;
  logic               out_valid;
  logic [DATA_WD-1:0] out_bus;
  logic               out_allowin;

  modport slave (
    input  in_valid,
    input  in_bus,
    output in_allowin,
    output out_valid,
    output out_bus,
    input  out_allowin
  );

  modport master (
    output in_valid,
    output in_bus,
    input  in_allowin,
    input  out_valid,
    input  out_bus,
    output out_allowin
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: a small circular FIFO of {PC, instruction} entries between the
// fetch stage and decode. flush discards everything (branch/redirect), reset
// clears the pointers and count synchronously.
// Optional macro FETCH_QUEUE_BYPASS_EN: when defined, an entry arriving at an
// empty queue is presented on out_bus in the same cycle and is not stored if
// the consumer takes it immediately.
module fetch_queue #(
  parameter  int DATA_WD = 64,
  parameter  int DEPTH   = 4,
  localparam int CNT_WD  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  fetch_queue_if.slave      bus,
  output logic [CNT_WD-1:0] count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_WD = $clog2(DEPTH);

  logic [DATA_WD-1:0] mem [DEPTH];
  logic [PTR_WD-1:0]  rd_ptr;
  logic [PTR_WD-1:0]  wr_ptr;
  logic [CNT_WD-1:0]  cnt_q;
  logic               push;
  logic               pop;
  logic               do_write;
  logic               do_read;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_WD-1:0] next_ptr(input logic [PTR_WD-1:0] p);
    return (p == PTR_WD'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign count = cnt_q;
  assign full  = (cnt_q == CNT_WD'(DEPTH));
  assign empty = (cnt_q == '0);

  // Acceptance depends only on stored state and flush, never on out_allowin.
  assign bus.in_allowin = !full && !flush;

  assign push = bus.in_valid && bus.in_allowin;
  assign pop  = bus.out_valid && bus.out_allowin;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_hit;

  // An entry arriving at an empty queue is offered straight to the consumer;
  // if taken it never touches storage, otherwise it is stored as usual.
  assign bypass_hit    = empty && bus.in_valid && !flush;
  assign bus.out_valid = bypass_hit || (!empty && !flush);
  assign bus.out_bus   = empty ? bus.in_bus : mem[rd_ptr];
  assign do_write      = push && !(bypass_hit && bus.out_allowin);
  assign do_read       = pop && !bypass_hit;
`else
  // Output is driven purely from storage, so a push shows up one cycle later.
  assign bus.out_valid = !empty && !flush;
  assign bus.out_bus   = mem[rd_ptr];
  assign do_write      = push;
  assign do_read       = pop;
`endif

  // Entry storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem[wr_ptr] <= bus.in_bus;
    end
  end

  // Pointer and occupancy bookkeeping; reset beats flush, flush beats transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_read) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (do_write && !do_read) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!do_write && do_read) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DATA_WD, default 64, SHALL set the entry width (PC 32 bits + instruction 32 bits).
REQ-002 Parameter DEPTH, default 4, SHALL set the entry count; legal range 2..16, not required to be a power of two.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-005 Port flush, input, 1 bit, SHALL discard all entries (branch taken or redirect).
REQ-006 Port in_valid, input, 1 bit, SHALL flag a valid producer entry on in_bus.
REQ-007 Port in_bus, input, DATA_WD bits, SHALL carry the producer entry.
REQ-008 Port in_allowin, output, 1 bit, SHALL signal the queue accepts an entry this cycle.
REQ-009 Port out_valid, output, 1 bit, SHALL flag a valid entry on out_bus.
REQ-010 Port out_bus, output, DATA_WD bits, SHALL carry the head entry.
REQ-011 Port out_allowin, input, 1 bit, SHALL signal the consumer takes out_bus this cycle.
REQ-012 Port count, output, $clog2(DEPTH+1) bits, SHALL report the stored entry count.
REQ-013 Ports full and empty, output, 1 bit each, SHALL equal (count==DEPTH) and (count==0).

Function
REQ-014 A push SHALL occur when in_valid && in_allowin; a pop SHALL occur when out_valid && out_allowin.
REQ-015 in_allowin SHALL equal !full && !flush, with no combinational path from out_allowin.
REQ-016 out_valid SHALL equal !empty && !flush when bypass is disabled; out_bus SHALL be the entry at the read pointer.
REQ-017 A push SHALL write in_bus at the write pointer and advance it; a pop SHALL advance the read pointer.
REQ-018 Both pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-020 count SHALL increment on push only, decrement on pop only, and never exceed DEPTH or drop below 0.
REQ-021 flush SHALL take priority over push and pop: pointers and count SHALL be 0 next cycle, and no transfer SHALL occur in the flush cycle.
REQ-022 Minimum latency from push to out_valid SHALL be 1 cycle when bypass is disabled.
REQ-023 Entry storage SHALL need no reset; only pointers and count are reset.

Reset
REQ-024 While reset is high, the next edge SHALL set read pointer, write pointer and count to 0.
REQ-025 After reset: out_valid=0, empty=1, full=0, count=0, in_allowin=1 (if flush=0).
REQ-026 reset SHALL override flush, push and pop in the same cycle; a mid-operation reset SHALL discard all entries.

Configuration
REQ-027 Macro FETCH_QUEUE_BYPASS_EN, when defined, SHALL enable same-cycle bypass.
REQ-028 With the macro defined, when empty && in_valid && !flush: out_valid SHALL be 1 and out_bus SHALL be in_bus.
REQ-029 With the macro defined, a bypassed entry consumed (out_allowin=1) SHALL not be written; if out_allowin=0 it SHALL be pushed normally.
REQ-030 Without the macro, out_valid and out_bus SHALL depend only on stored state and flush (REQ-016).

Verification
REQ-031 After reset, push 0x1FC00000_24010001 with out_allowin=0 -> next cycle count=1, out_valid=1, out_bus=0x1FC00000_24010001.
REQ-032 With DEPTH=4 and out_allowin=0, push 5 entries -> full=1 and in_allowin=0 after the 4th; the 5th is held; order 1..4 is preserved on drain.
REQ-033 With count=2, push and pop in one cycle for 10 cycles, with pointers crossing the wrap -> count stays 2 and the output sequence matches the input.
REQ-034 With count=3, assert flush alongside in_valid=1 and out_allowin=1 -> no transfer; next cycle count=0, empty=1.
REQ-035 With count=2, assert reset -> next cycle count=0 and out_valid=0; the first push after reset appears alone at the head.
REQ-036 With FETCH_QUEUE_BYPASS_EN defined, empty queue, in_valid=1 and out_allowin=1 -> same-cycle out_bus=in_bus; count stays 0.
